// File: rtl/icache_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// icache_fetch_ctrl_if
// Fetch-side and memory-side bus of the instruction cache.
//   pc_addr  : fetch byte address from the core ([1:0] ignored)
//   flush    : invalidate every cache line (fence.i)
//   inst_out : instruction handed to decode (NOP while stalled)
//   stall    : 1 = inst_out not valid, core freezes its PC
//   mem_addr : word-aligned byte address into instruction memory
//   mem_inst : instruction memory read data, combinational from mem_addr
// Modports:
//   slave  : the cache itself
//   master : the environment (core plus instruction memory)
// ---------------------------------------------------------------------------
interface icache_fetch_ctrl_if;
    logic [31:0] pc_addr;
    logic        flush;
    logic [31:0] inst_out;
    logic        stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_inst;

    modport slave  (input  pc_addr, flush, mem_inst,
                    output inst_out, stall, mem_addr);
    modport master (output pc_addr, flush, mem_inst,
                    input  inst_out, stall, mem_addr);
endinterface

// File: rtl/icache_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// icache_fetch_ctrl
// Direct-mapped, read-only instruction cache between the core PC and a
// combinational instruction memory. Hits return the instruction in the same
// cycle; a miss stalls the core and refills the whole line, one word per
// cycle, then the line becomes visible.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   bus      : icache_fetch_ctrl_if.slave (pc_addr, flush, inst_out, stall,
//              mem_addr, mem_inst)
//   hit_cnt  : (ICACHE_PERF_EN only) IDLE cycles that hit
//   miss_cnt : (ICACHE_PERF_EN only) IDLE cycles that detected a miss
// Optional feature macro: ICACHE_PERF_EN (adds the two performance counters).
// ---------------------------------------------------------------------------
module icache_fetch_ctrl #(
    parameter int          LINES       = 16,
    parameter int          BLOCK_WORDS = 4,
    parameter logic [31:0] NOP_INST    = 32'h00000013
) (
    input  logic                 clk,
    input  logic                 rst,
    icache_fetch_ctrl_if.slave   bus
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]          hit_cnt,
    output logic [31:0]          miss_cnt
`endif
);
    localparam int IDX_W = $clog2(LINES);
    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int TAG_W = 32 - IDX_W - OFF_W - 2;
    localparam logic [OFF_W-1:0] CNT_ONE  = OFF_W'(1);
    localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(BLOCK_WORDS - 1);

    typedef enum logic {IDLE, REFILL} state_t;

    // Control state (reset)
    state_t             r_state;
    logic [OFF_W-1:0]   r_cnt;
    logic [TAG_W-1:0]   r_ltag;
    logic [IDX_W-1:0]   r_lidx;
    logic [LINES-1:0]   r_valid;

    // Storage (never reset; guarded by r_valid)
    logic [TAG_W-1:0]   r_tag_mem [LINES];
    logic [31:0]        r_data    [LINES][BLOCK_WORDS];

    logic [OFF_W-1:0]   w_off;
    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit;
    logic               w_unused;

    assign w_off    = bus.pc_addr[OFF_W+1:2];
    assign w_idx    = bus.pc_addr[IDX_W+OFF_W+1:OFF_W+2];
    assign w_tag    = bus.pc_addr[31:IDX_W+OFF_W+2];
    assign w_hit    = r_valid[w_idx] && (r_tag_mem[w_idx] == w_tag);
    // Byte-offset bits of the PC carry no information for a word fetch.
    assign w_unused = &{1'b0, bus.pc_addr[1:0]};

    // Hit path is purely combinational so a hit costs no cycle.
    always_comb begin
        bus.inst_out = NOP_INST;
        bus.stall    = 1'b1;
        bus.mem_addr = {bus.pc_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
        if (r_state == IDLE) begin
            if (w_hit) begin
                bus.inst_out = r_data[w_idx][w_off];
                bus.stall    = 1'b0;
            end
        end else begin
            bus.mem_addr = {r_ltag, r_lidx, r_cnt, 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ltag  <= '0;
            r_lidx  <= '0;
            r_valid <= '0;
        end else if (bus.flush) begin
            // Flush wins over everything, including refill completion, so a
            // half-written line can never be marked valid.
            r_valid <= '0;
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_hit) begin
                        r_ltag  <= w_tag;
                        r_lidx  <= w_idx;
                        r_cnt   <= '0;
                        r_state <= REFILL;
                    end
                end
                REFILL: begin
                    r_cnt <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_LAST) begin
                        r_valid[r_lidx] <= 1'b1;
                        r_state         <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Line storage is written every REFILL cycle; an aborted refill leaves
    // junk behind, but the line's valid bit stays clear so it is never seen.
    always_ff @(posedge clk) begin
        if (r_state == REFILL) begin
            r_data[r_lidx][r_cnt] <= bus.mem_inst;
            if (r_cnt == CNT_LAST) begin
                r_tag_mem[r_lidx] <= r_ltag;
            end
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (r_state == IDLE) begin
            if (w_hit) begin
                hit_cnt  <= hit_cnt + 32'd1;
            end else begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_icache_fetch_ctrl
// Table of per-cycle vectors {rst, flush, pc_addr, expected stall, inst_out,
// mem_addr}; each vector's expectation goes through a scoreboard queue when
// driven and is popped when the outputs are sampled on the falling edge.
// Instruction memory is a combinational function of mem_addr.
// ---------------------------------------------------------------------------
module tb_icache_fetch_ctrl;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic        rs;
        logic        fl;
        logic [31:0] pc;
        logic        st;
        logic [31:0] inst;
        logic [31:0] maddr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    icache_fetch_ctrl_if bus ();

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache_fetch_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus)
`ifdef ICACHE_PERF_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        case (a)
            32'h0:   mem_f = 32'h00500113;
            32'h4:   mem_f = 32'h00C00193;
            default: mem_f = 32'hE000_0000 | a;
        endcase
    endfunction

    assign bus.mem_inst = mem_f(bus.mem_addr);

    vec_t vecs[$];
    vec_t sb[$];

    function automatic void add(input logic rs, input logic fl, input logic [31:0] pc,
                                input logic st, input logic [31:0] inst,
                                input logic [31:0] maddr);
        vec_t v;
        v.rs = rs; v.fl = fl; v.pc = pc; v.st = st; v.inst = inst; v.maddr = maddr;
        vecs.push_back(v);
    endfunction

    // Detect cycle plus four refill cycles for the line holding pc.
    function automatic void add_miss(input logic [31:0] pc);
        logic [31:0] base;
        base = {pc[31:4], 4'h0};
        add(1'b0, 1'b0, pc, 1'b1, NOP, base);
        for (int k = 0; k < 4; k++) add(1'b0, 1'b0, pc, 1'b1, NOP, base + 32'(4 * k));
    endfunction

    function automatic void add_hit(input logic [31:0] pc);
        add(1'b0, 1'b0, pc, 1'b0, mem_f(pc), {pc[31:4], 4'h0});
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    initial begin
        vec_t e;
        int   waited;

        // Cold miss and sequential hits
        add_miss(32'h0);
        add_hit(32'h0);
        add_hit(32'h4);
        add_hit(32'h8);
        add_hit(32'hC);
        // Conflict on index 0, then the old line misses again
        add_miss(32'h100);
        add_hit(32'h100);
        add_hit(32'h104);
        add_miss(32'h0);
        add_hit(32'h0);
        // Second line (index 1)
        add_miss(32'h14);
        add_hit(32'h14);
        // Flush in the 2nd REFILL cycle of line 0x20
        add(1'b0, 1'b0, 32'h20, 1'b1, NOP, 32'h20);
        add(1'b0, 1'b0, 32'h20, 1'b1, NOP, 32'h20);
        add(1'b0, 1'b1, 32'h20, 1'b1, NOP, 32'h24);
        add_miss(32'h0);
        add_hit(32'h0);
        add_miss(32'h14);
        add_hit(32'h14);
        // Flush while hitting: lookup still sees the pre-flush line
        add(1'b0, 1'b1, 32'h0, 1'b0, 32'h00500113, 32'h0);
        add_miss(32'h0);
        add_hit(32'h0);
        // Reset in the 3rd REFILL cycle of line 0x30
        add(1'b0, 1'b0, 32'h30, 1'b1, NOP, 32'h30);
        add(1'b0, 1'b0, 32'h30, 1'b1, NOP, 32'h30);
        add(1'b0, 1'b0, 32'h30, 1'b1, NOP, 32'h34);
        add(1'b1, 1'b0, 32'h30, 1'b1, NOP, 32'h38);
        add_miss(32'h30);
        add_hit(32'h38);
        add(1'b0, 1'b0, 32'h0, 1'b1, NOP, 32'h0);

        rst          = 1'b1;
        bus.flush    = 1'b0;
        bus.pc_addr  = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset stall", 32'(bus.stall), 32'd1);
        chk("reset inst",  bus.inst_out,   NOP);
        chk("reset maddr", bus.mem_addr,   32'h0);
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            rst         = vecs[i].rs;
            bus.flush   = vecs[i].fl;
            bus.pc_addr = vecs[i].pc;
            sb.push_back(vecs[i]);
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("v%0d stall", i), 32'(bus.stall), 32'(e.st));
            chk($sformatf("v%0d inst",  i), bus.inst_out,   e.inst);
            chk($sformatf("v%0d maddr", i), bus.mem_addr,   e.maddr);
            @(posedge clk);
            #1;
        end

`ifdef ICACHE_PERF_EN
        rst         = 1'b1;
        bus.flush   = 1'b0;
        bus.pc_addr = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        waited = 0;
        @(negedge clk);
        while (bus.stall !== 1'b0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (waited >= 20) begin
            n_fail++;
            $display("FAIL perf refill timeout: got stall %b after %0d cycles, want 0", bus.stall, waited);
        end
        for (int a = 4; a <= 12; a += 4) begin
            @(posedge clk);
            #1;
            bus.pc_addr = 32'(a);
        end
        @(posedge clk);
        #1;
        chk("perf hit_cnt",  hit_cnt,  32'd4);
        chk("perf miss_cnt", miss_cnt, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
